// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mdu_state_t;

    localparam int MDU_ITER  = 32;
    localparam int MDU_CNT_W = $clog2(MDU_ITER);

endpackage

// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit: 32-cycle shift-add multiply and restoring
// divide on magnitudes, followed by one sign-fixup cycle that writes HI/LO.
//
// state | meaning
// IDLE  | accept start and MTHI/MTLO, capture magnitudes and signs
// CALC  | one multiplier/quotient bit per cycle, counter 0..31
// FIX   | apply signs, write HI/LO, pulse done
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t           state;
    mdu_op_t              op_q;
    logic [MDU_CNT_W-1:0] cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic [WIDTH-1:0]     a_raw;
    logic                 sign_a;
    logic                 sign_b;
    logic                 b_zero;

    logic                 in_signed;
    logic                 in_div;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 is_div;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_rem;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_sub;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    always_comb begin
        in_signed = ~op[0];
        in_div    = op[1];
        a_mag     = (in_signed && A[WIDTH-1]) ? -A : A;
        b_mag     = (in_signed && B[WIDTH-1]) ? -B : B;
    end

    // acc low half holds the multiplier (multiply) or dividend (divide);
    // opnd holds the multiplicand or divisor.
    always_comb begin
        is_div   = (op_q == DIV) || (op_q == DIVU);
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        div_rem  = acc[2*WIDTH-1:WIDTH-1];
        div_ge   = div_rem >= {1'b0, opnd};
        div_sub  = div_rem[WIDTH-1:0] - opnd;
        div_next = div_ge ? {div_sub, acc[WIDTH-2:0], 1'b1}
                          : {acc[2*WIDTH-2:0], 1'b0};
    end

    always_comb begin
        fix_hi = acc[2*WIDTH-1:WIDTH];
        fix_lo = acc[WIDTH-1:0];
        case (op_q)
            MULT: begin
                if (sign_a ^ sign_b) {fix_hi, fix_lo} = -acc;
            end
            DIV, DIVU: begin
                if (b_zero) begin
                    fix_hi = a_raw;
                    fix_lo = '1;
                end else begin
                    if (sign_a ^ sign_b) fix_lo = -acc[WIDTH-1:0];
                    if (sign_a)          fix_hi = -acc[2*WIDTH-1:WIDTH];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= MULT;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            b_zero   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (start) begin
                        op_q   <= mdu_op_t'(op);
                        sign_a <= in_signed & A[WIDTH-1];
                        sign_b <= in_signed & B[WIDTH-1];
                        a_raw  <= A;
                        b_zero <= (B == '0);
                        opnd   <= in_div ? b_mag : a_mag;
                        acc    <= {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == MDU_CNT_W'(MDU_ITER - 1)) state <= FIX;
                end
                FIX: begin
                    hi       <= fix_hi;
                    lo       <= fix_lo;
                    done     <= 1'b1;
                    div_zero <= is_div & b_zero;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS execute stage. It runs alongside the combinational ALU operation modules (AND/OR/NOT/ADD…) and consumes the same 32-bit operands A/B. It computes MULT/MULTU/DIV/DIVU over 32 iterations and holds the results in architectural HI/LO registers. Control stalls the pipeline on `busy`; MFHI/MFLO read `hi`/`lo` directly, and MTHI/MTLO write them.

## Interface
- `WIDTH`, 32: operand and HI/LO width. Only 32 is verified.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch an operation; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `A`  in  WIDTH  multiplicand / dividend.
- `B`  in  WIDTH  multiplier / divisor.
- `mthi`  in  1  write `wdata` to HI.
- `mtlo`  in  1  write `wdata` to LO.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse when HI/LO are updated by an operation.
- `div_zero`  out  1  valid with `done`; the finished DIV/DIVU had B == 0.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- **States:**
  - IDLE: on `start`, capture the operands and go to CALC. Signed ops capture |A| and |B| plus the sign of each.
  - CALC: runs exactly 32 cycles, with a 5-bit counter from 0 to 31.
    - Multiply: shift-add, one multiplier bit per cycle, 64-bit accumulator.
    - Divide: restoring division, one quotient bit per cycle.
    - After count 31, go to FIX.
  - FIX: apply sign correction, write HI/LO, go to IDLE.
- **Result rules:**
  - MULT/MULTU: {hi, lo} = 64-bit product. For MULT, the product is negated when the operand signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder. For DIV, the quotient is negated when the signs differ, and the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives lo = 0x80000000, hi = 0. This falls out of the magnitude algorithm; no special case is needed.
  - Divide by zero (B == 0): lo = 0xFFFFFFFF, hi = A as captured (raw, not magnitude), `div_zero` = 1. Latency is unchanged.
- **Control rules:**
  - `start` while `busy` is ignored; the in-flight operation is unaffected.
  - `mthi`/`mtlo` write only when not busy. While busy they are ignored; control stalls them.
  - `mthi`/`mtlo` in the same IDLE cycle as `start`: the write takes effect and the operation launches. The later FIX overwrites both HI and LO.
  - `mthi` and `mtlo` asserted together write both registers.
- **Reset values (asynchronous assert):** state IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0, internal accumulators cleared. Reset during CALC aborts the operation with no HI/LO update.

## Timing
- E0 is the edge that samples `start` in IDLE.
- `busy` = 1 from after E0 through the FIX edge (E33).
- CALC iterations occur on E1..E32; FIX occurs on E33.
- After E33:
  - `hi`/`lo` hold the new values.
  - `done` = 1 for exactly one cycle.
  - `busy` = 0.
  - A new `start` is accepted on E34.
- Fixed latency: results are visible 33 cycles after the start edge, for every op including divide by zero.
- `div_zero` is registered together with `done` and clears on the next edge.
- `busy` and `done` come from the state register only, with no combinational path from `start`.
- `hi`/`lo` are register outputs and stay stable throughout CALC.

## Structure
- Package `mdu_pkg`:
  - `mdu_op_t` enum: MULT, MULTU, DIV, DIVU.
  - `mdu_state_t` enum: IDLE, CALC, FIX.
  - `MDU_ITER` = 32.
- Single module; no sub-module is needed. The multiply and divide datapaths share the 64-bit accumulator and the iteration counter.

## Test plan
- MULTU A = 0xFFFFFFFF, B = 0xFFFFFFFF → after 33 cycles: hi = 0xFFFFFFFE, lo = 0x00000001, `done` pulses once, `busy` low 33 cycles after start.
- MULT A = 0xFFFFFFFD (−3), B = 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. DIV A = 0xFFFFFFF9 (−7), B = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU A = 100, B = 0 → lo = 0xFFFFFFFF, hi = 100, `div_zero` = 1 with `done`.
  - DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0, `div_zero` = 0.
- Busy rules: `start` with new operands at cycle 5 of an operation → ignored, first result intact. `mthi` of 0x1234 while busy → ignored. `mthi` of 0x1234 in IDLE → hi = 0x1234 next cycle.
- Reset mid-operation: `rst_n` low at cycle 10 → `busy`, hi, lo = 0 immediately, with no `done`. After release, a fresh MULTU 3 × 4 → lo = 12, hi = 0.
- Back-to-back: second `start` on E34 → accepted; its `done` arrives 33 cycles later.
